// File: rtl/load_store_unit.sv
// RV32I load/store engine: one request at a time, word-addressed memory
// port with byte strobes, aligned/extended load write-back and error pulse.
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [2:0]  req_funct3_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [4:0]  req_rd_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_wstrb_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    output logic        wb_en_o,
    output logic [4:0]  wb_rd_o,
    output logic [31:0] wb_data_o,
    output logic        err_o
);

    localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        WB,
        ERR
    } state_e;

    state_e state_q, state_d;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       f3_q, f3_d;
    logic [1:0]       lane_q, lane_d;
    logic [4:0]       rd_q, rd_d;
    logic             mem_req_q, mem_req_d;
    logic             mem_we_q, mem_we_d;
    logic [31:0]      mem_addr_q, mem_addr_d;
    logic [31:0]      mem_wdata_q, mem_wdata_d;
    logic [3:0]       mem_wstrb_q, mem_wstrb_d;
    logic             wb_en_q, wb_en_d;
    logic [4:0]       wb_rd_q, wb_rd_d;
    logic [31:0]      wb_data_q, wb_data_d;
    logic             err_q, err_d;

    logic        bad_req;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] ld_ext;

    // Misalignment and illegal funct3 are both rejected before any access.
    always_comb begin
        bad_req = 1'b0;
        if (req_we_i) begin
            bad_req = req_funct3_i > 3'd2;
        end else begin
            bad_req = (req_funct3_i == 3'd3) || (req_funct3_i == 3'd6) ||
                      (req_funct3_i == 3'd7);
        end
        if (req_funct3_i[1:0] == 2'd1 && req_addr_i[0]) begin
            bad_req = 1'b1;
        end
        if (req_funct3_i[1:0] == 2'd2 && req_addr_i[1:0] != 2'd0) begin
            bad_req = 1'b1;
        end
    end

    always_comb begin
        rd_byte = 8'h00;
        unique case (lane_q)
            2'd0: rd_byte = mem_rdata_i[7:0];
            2'd1: rd_byte = mem_rdata_i[15:8];
            2'd2: rd_byte = mem_rdata_i[23:16];
            2'd3: rd_byte = mem_rdata_i[31:24];
        endcase
        rd_half = lane_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
        case (f3_q)
            3'd0:    ld_ext = {{24{rd_byte[7]}}, rd_byte};
            3'd1:    ld_ext = {{16{rd_half[15]}}, rd_half};
            3'd4:    ld_ext = {24'h0, rd_byte};
            3'd5:    ld_ext = {16'h0, rd_half};
            default: ld_ext = mem_rdata_i;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        f3_d        = f3_q;
        lane_d      = lane_q;
        rd_d        = rd_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
        wb_en_d     = 1'b0;
        wb_rd_d     = wb_rd_q;
        wb_data_d   = wb_data_q;
        err_d       = 1'b0;

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (req_valid_i) begin
                    if (bad_req) begin
                        state_d = ERR;
                        err_d   = 1'b1;
                    end else begin
                        state_d     = ACCESS;
                        f3_d        = req_funct3_i;
                        lane_d      = req_addr_i[1:0];
                        rd_d        = req_rd_i;
                        mem_req_d   = 1'b1;
                        mem_we_d    = req_we_i;
                        mem_addr_d  = {req_addr_i[31:2], 2'b00};
                        mem_wdata_d = req_wdata_i;
                        mem_wstrb_d = 4'b0000;
                        if (req_we_i) begin
                            case (req_funct3_i)
                                3'd0: begin
                                    mem_wdata_d = {4{req_wdata_i[7:0]}};
                                    mem_wstrb_d = 4'b0001 << req_addr_i[1:0];
                                end
                                3'd1: begin
                                    mem_wdata_d = {2{req_wdata_i[15:0]}};
                                    mem_wstrb_d = 4'b0011 << req_addr_i[1:0];
                                end
                                default: mem_wstrb_d = 4'b1111;
                            endcase
                        end
                    end
                end
            end
            ACCESS: begin
                cnt_d = cnt_q + 1'b1;
                // Ack wins over a timeout expiring on the same edge.
                if (mem_ack_i || cnt_q == CNT_LAST) begin
                    mem_req_d   = 1'b0;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = '0;
                    mem_wdata_d = '0;
                    mem_wstrb_d = '0;
                    if (!mem_ack_i) begin
                        state_d = ERR;
                        err_d   = 1'b1;
                    end else if (mem_we_q) begin
                        state_d = IDLE;
                    end else begin
                        state_d   = WB;
                        wb_en_d   = rd_q != 5'd0;
                        wb_rd_d   = rd_q;
                        wb_data_d = ld_ext;
                    end
                end
            end
            WB:  state_d = IDLE;
            ERR: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            f3_q        <= '0;
            lane_q      <= '0;
            rd_q        <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
            wb_en_q     <= 1'b0;
            wb_rd_q     <= '0;
            wb_data_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            f3_q        <= f3_d;
            lane_q      <= lane_d;
            rd_q        <= rd_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
            wb_en_q     <= wb_en_d;
            wb_rd_q     <= wb_rd_d;
            wb_data_q   <= wb_data_d;
            err_q       <= err_d;
        end
    end

    assign req_ready_o = state_q == IDLE;
    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign mem_wstrb_o = mem_wstrb_q;
    assign wb_en_o     = wb_en_q;
    assign wb_rd_o     = wb_rd_q;
    assign wb_data_o   = wb_data_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: extension, store lanes, errors,
// timeout, late ack and reset during an access.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [2:0]  req_funct3_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic [4:0]  req_rd_i;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_wstrb_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;
    logic        wb_en_o;
    logic [4:0]  wb_rd_o;
    logic [31:0] wb_data_o;
    logic        err_o;

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_we_i     (req_we_i),
        .req_funct3_i (req_funct3_i),
        .req_addr_i   (req_addr_i),
        .req_wdata_i  (req_wdata_i),
        .req_rd_i     (req_rd_i),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_wstrb_o  (mem_wstrb_o),
        .mem_ack_i    (mem_ack_i),
        .mem_rdata_i  (mem_rdata_i),
        .wb_en_o      (wb_en_o),
        .wb_rd_o      (wb_rd_o),
        .wb_data_o    (wb_data_o),
        .err_o        (err_o)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Present one request for a cycle; returns at the negedge after acceptance.
    task automatic issue(input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [4:0] rd);
        @(negedge clk);
        req_valid_i  = 1'b1;
        req_we_i     = we;
        req_funct3_i = f3;
        req_addr_i   = addr;
        req_wdata_i  = wd;
        req_rd_i     = rd;
        chk("ready_pre", 32'(req_ready_o), 32'd1);
        @(negedge clk);
        req_valid_i = 1'b0;
    endtask

    task automatic do_load(input string tag, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [4:0] rd,
                           input logic [31:0] rdata, input int wait_n,
                           input logic [31:0] exp_d);
        issue(1'b0, f3, addr, 32'h0, rd);
        chk({tag, "_addr"}, mem_addr_o, {addr[31:2], 2'b00});
        chk({tag, "_we"}, {mem_we_o, mem_wstrb_o}, 32'h0);
        for (int i = 1; i <= wait_n; i++) begin
            if (i > 1) @(negedge clk);
            chk({tag, "_req"}, 32'(mem_req_o), 32'd1);
            if (i == wait_n) begin
                mem_ack_i   = 1'b1;
                mem_rdata_i = rdata;
            end
        end
        @(negedge clk);
        mem_ack_i   = 1'b0;
        mem_rdata_i = 32'h0;
        chk({tag, "_wben"}, 32'(wb_en_o), 32'(rd != 5'd0));
        chk({tag, "_wbrd"}, 32'(wb_rd_o), 32'(rd));
        chk({tag, "_wbdata"}, wb_data_o, exp_d);
        chk({tag, "_busy"}, {mem_req_o, req_ready_o, err_o}, 32'h0);
        @(negedge clk);
        chk({tag, "_done"}, {wb_en_o, req_ready_o}, 32'h1);
    endtask

    task automatic do_store(input string tag, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wd,
                            input logic [31:0] exp_wd,
                            input logic [3:0] exp_strb);
        issue(1'b1, f3, addr, wd, 5'd0);
        chk({tag, "_req"}, {mem_req_o, mem_we_o}, 32'h3);
        chk({tag, "_addr"}, mem_addr_o, {addr[31:2], 2'b00});
        chk({tag, "_wdata"}, mem_wdata_o, exp_wd);
        chk({tag, "_wstrb"}, 32'(mem_wstrb_o), 32'(exp_strb));
        mem_ack_i = 1'b1;
        @(negedge clk);
        mem_ack_i = 1'b0;
        chk({tag, "_done"}, {mem_req_o, wb_en_o, err_o, req_ready_o}, 32'h1);
    endtask

    task automatic do_err(input string tag, input logic we,
                          input logic [2:0] f3, input logic [31:0] addr);
        issue(we, f3, addr, 32'h0, 5'd3);
        chk({tag, "_err"}, {err_o, mem_req_o, wb_en_o, req_ready_o}, 32'h8);
        @(negedge clk);
        chk({tag, "_back"}, {err_o, mem_req_o, wb_en_o, req_ready_o}, 32'h1);
    endtask

    initial begin
        rst          = 1'b1;
        req_valid_i  = 1'b0;
        req_we_i     = 1'b0;
        req_funct3_i = 3'd0;
        req_addr_i   = 32'h0;
        req_wdata_i  = 32'h0;
        req_rd_i     = 5'd0;
        mem_ack_i    = 1'b0;
        mem_rdata_i  = 32'h0;
        repeat (3) @(negedge clk);
        chk("rst_out", {mem_req_o, mem_we_o, mem_wstrb_o, wb_en_o, err_o},
            32'h0);
        chk("rst_addr", mem_addr_o ^ mem_wdata_o ^ wb_data_o, 32'h0);
        chk("rst_ready", 32'(req_ready_o), 32'd1);
        rst = 1'b0;

        do_load("lb", 3'd0, 32'h1003, 5'd5, 32'h80FF_0000, 3, 32'hFFFF_FF80);
        do_load("lhu", 3'd5, 32'h1002, 5'd6, 32'hBEEF_1234, 1, 32'h0000_BEEF);
        do_load("lh", 3'd1, 32'h1002, 5'd7, 32'hBEEF_1234, 2, 32'hFFFF_BEEF);
        do_load("lh0", 3'd1, 32'h1000, 5'd7, 32'hBEEF_1234, 1, 32'h0000_1234);
        do_load("lbu", 3'd4, 32'h1001, 5'd8, 32'hBEEF_8312, 1, 32'h0000_0083);
        do_load("lbp", 3'd0, 32'h1000, 5'd9, 32'h1234_567F, 1, 32'h0000_007F);
        do_load("lw", 3'd2, 32'h1004, 5'd31, 32'hCAFE_F00D, 2, 32'hCAFE_F00D);

        do_store("sb", 3'd0, 32'h2001, 32'h0000_00A5, 32'hA5A5_A5A5, 4'b0010);
        do_store("sh", 3'd1, 32'h2002, 32'h1234_BEEF, 32'hBEEF_BEEF, 4'b1100);
        do_store("sw", 3'd2, 32'h2004, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 4'b1111);

        do_err("lw_mis", 1'b0, 3'd2, 32'h3002);
        do_err("lh_mis", 1'b0, 3'd1, 32'h3001);
        do_err("ld_f3", 1'b0, 3'd6, 32'h3000);
        do_err("st_f3", 1'b1, 3'd4, 32'h3000);

        issue(1'b0, 3'd2, 32'h4000, 32'h0, 5'd4);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            chk("to_req", {mem_req_o, err_o}, 32'h2);
        end
        @(negedge clk);
        chk("to_err", {err_o, mem_req_o, wb_en_o, req_ready_o}, 32'h8);
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'h1111_1111;
        @(negedge clk);
        mem_ack_i = 1'b0;
        chk("late_ack", {err_o, mem_req_o, wb_en_o, req_ready_o}, 32'h1);
        @(negedge clk);
        chk("late_ack2", {err_o, mem_req_o, wb_en_o}, 32'h0);

        do_load("ack_edge", 3'd2, 32'h4004, 5'd10, 32'h0BAD_CAFE, 4,
                32'h0BAD_CAFE);

        issue(1'b0, 3'd2, 32'h5000, 32'h0, 5'd11);
        chk("mid_req", 32'(mem_req_o), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst", {mem_req_o, wb_en_o, err_o, req_ready_o}, 32'h1);
        @(negedge clk);
        chk("mid_rst2", {mem_req_o, wb_en_o, err_o, req_ready_o}, 32'h1);

        do_load("rd0", 3'd2, 32'h6000, 5'd0, 32'h7654_3210, 1, 32'h7654_3210);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
